// File: rtl/dpram_port_requester.sv
// -----------------------------------------------------------------------------
// dpram_port_requester
//
// Request-buffering front end for one port of a dual-port RAM. Client
// commands (read/write) enter a command FIFO over a valid/ready channel and
// are issued to the RAM strictly in order from registered FIFO storage.
// Read data returns one cycle after an accepted read and is captured into a
// response FIFO that is drained by the client over a valid/ready channel.
// A credit check keeps reads from issuing unless a response slot is
// guaranteed, so capture never overflows the response FIFO.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         client command handshake
//   req_addr/req_data/req_we    command fields (data ignored for reads)
//   rsp_valid/rsp_ready         client read-data handshake
//   rsp_data                    read data, in command order
//   ram_addr/ram_data/ram_we    to RAM port (held at 0 when ram_valid=0)
//   ram_valid/ram_ready         RAM request handshake
//   ram_q                       RAM read data, one cycle after a read
//
// Optional build macro DPRAM_REQ_STATS_EN adds saturating 16-bit counters:
//   stat_rd_cnt, stat_wr_cnt    accepted RAM read / write transfers
//   stat_stall_cnt              cycles with a queued command held by credit
// -----------------------------------------------------------------------------
module dpram_port_requester #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_we,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              ram_valid,
    input  logic              ram_ready,
    input  logic [DATA_W-1:0] ram_q
`ifdef DPRAM_REQ_STATS_EN
    ,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_stall_cnt
`endif
);

    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int RSP_AW = $clog2(RSP_DEPTH);

    localparam logic [CMD_AW-1:0] CMD_PTR_ONE  = CMD_AW'(1);
    localparam logic [CMD_AW:0]   CMD_CNT_ONE  = (CMD_AW+1)'(1);
    localparam logic [CMD_AW:0]   CMD_CNT_ZERO = (CMD_AW+1)'(0);
    localparam logic [CMD_AW:0]   CMD_CNT_FULL = (CMD_AW+1)'(CMD_DEPTH);
    localparam logic [RSP_AW-1:0] RSP_PTR_ONE  = RSP_AW'(1);
    localparam logic [RSP_AW:0]   RSP_CNT_ONE  = (RSP_AW+1)'(1);
    localparam logic [RSP_AW:0]   RSP_CNT_ZERO = (RSP_AW+1)'(0);
    localparam logic [RSP_AW+1:0] RSP_LIMIT    = (RSP_AW+2)'(RSP_DEPTH);

    // Command FIFO storage and state
    logic [ADDR_W-1:0] cmd_addr_mem_r [CMD_DEPTH];
    logic [DATA_W-1:0] cmd_data_mem_r [CMD_DEPTH];
    logic [CMD_DEPTH-1:0] cmd_we_mem_r;
    logic [CMD_AW-1:0] cmd_wr_ptr_r;
    logic [CMD_AW-1:0] cmd_rd_ptr_r;
    logic [CMD_AW:0]   cmd_count_r;

    // Response FIFO storage and state
    logic [DATA_W-1:0] rsp_mem_r [RSP_DEPTH];
    logic [RSP_AW-1:0] rsp_wr_ptr_r;
    logic [RSP_AW-1:0] rsp_rd_ptr_r;
    logic [RSP_AW:0]   rsp_count_r;

    logic rd_pending_r;

    logic              cmd_empty_s;
    logic              cmd_full_s;
    logic              cmd_push_s;
    logic              cmd_pop_s;
    logic              head_we_s;
    logic              credit_ok_s;
    logic [RSP_AW+1:0] credit_sum_s;
    logic              ram_valid_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              rsp_empty_s;
    logic              rsp_pop_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_data_s;
    logic              ram_we_s;
    logic [DATA_W-1:0] rsp_data_s;

    // Handshake decode and output steering, all derived from registered state
    always_comb begin
        cmd_empty_s  = (cmd_count_r == CMD_CNT_ZERO);
        cmd_full_s   = (cmd_count_r == CMD_CNT_FULL);
        rsp_empty_s  = (rsp_count_r == RSP_CNT_ZERO);
        head_we_s    = cmd_we_mem_r[cmd_rd_ptr_r];
        // An in-flight read already owns a response slot.
        credit_sum_s = {1'b0, rsp_count_r} + {{(RSP_AW+1){1'b0}}, rd_pending_r};
        credit_ok_s  = (credit_sum_s < RSP_LIMIT);
        ram_valid_s  = !cmd_empty_s && (head_we_s || credit_ok_s);
        // Gating with rst_n keeps req_ready low for the whole reset window.
        cmd_push_s   = req_valid && rst_n && !cmd_full_s;
        cmd_pop_s    = ram_valid_s && ram_ready;
        rd_acc_s     = cmd_pop_s && !head_we_s;
        wr_acc_s     = cmd_pop_s && head_we_s;
        rsp_pop_s    = !rsp_empty_s && rsp_ready;
        if (ram_valid_s) begin
            ram_addr_s = cmd_addr_mem_r[cmd_rd_ptr_r];
            ram_data_s = cmd_data_mem_r[cmd_rd_ptr_r];
            ram_we_s   = head_we_s;
        end else begin
            ram_addr_s = {ADDR_W{1'b0}};
            ram_data_s = {DATA_W{1'b0}};
            ram_we_s   = 1'b0;
        end
        if (!rsp_empty_s) begin
            rsp_data_s = rsp_mem_r[rsp_rd_ptr_r];
        end else begin
            rsp_data_s = {DATA_W{1'b0}};
        end
    end

    assign req_ready = rst_n && !cmd_full_s;
    assign ram_valid = ram_valid_s;
    assign ram_addr  = ram_addr_s;
    assign ram_data  = ram_data_s;
    assign ram_we    = ram_we_s;
    assign rsp_valid = !rsp_empty_s;
    assign rsp_data  = rsp_data_s;

    // Command FIFO storage write (contents need no reset; count gates use)
    always_ff @(posedge clk) begin
        if (cmd_push_s) begin
            cmd_addr_mem_r[cmd_wr_ptr_r] <= req_addr;
            cmd_data_mem_r[cmd_wr_ptr_r] <= req_data;
            cmd_we_mem_r[cmd_wr_ptr_r]   <= req_we;
        end
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_wr_ptr_r <= {CMD_AW{1'b0}};
            cmd_rd_ptr_r <= {CMD_AW{1'b0}};
            cmd_count_r  <= CMD_CNT_ZERO;
        end else begin
            if (cmd_push_s) begin
                cmd_wr_ptr_r <= cmd_wr_ptr_r + CMD_PTR_ONE;
            end
            if (cmd_pop_s) begin
                cmd_rd_ptr_r <= cmd_rd_ptr_r + CMD_PTR_ONE;
            end
            case ({cmd_push_s, cmd_pop_s})
                2'b10:   cmd_count_r <= cmd_count_r + CMD_CNT_ONE;
                2'b01:   cmd_count_r <= cmd_count_r - CMD_CNT_ONE;
                default: cmd_count_r <= cmd_count_r;
            endcase
        end
    end

    // Response FIFO storage write: ram_q is valid the cycle after a read
    always_ff @(posedge clk) begin
        if (rd_pending_r) begin
            rsp_mem_r[rsp_wr_ptr_r] <= ram_q;
        end
    end

    // Read tracking and response FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pending_r <= 1'b0;
            rsp_wr_ptr_r <= {RSP_AW{1'b0}};
            rsp_rd_ptr_r <= {RSP_AW{1'b0}};
            rsp_count_r  <= RSP_CNT_ZERO;
        end else begin
            rd_pending_r <= rd_acc_s;
            if (rd_pending_r) begin
                rsp_wr_ptr_r <= rsp_wr_ptr_r + RSP_PTR_ONE;
            end
            if (rsp_pop_s) begin
                rsp_rd_ptr_r <= rsp_rd_ptr_r + RSP_PTR_ONE;
            end
            case ({rd_pending_r, rsp_pop_s})
                2'b10:   rsp_count_r <= rsp_count_r + RSP_CNT_ONE;
                2'b01:   rsp_count_r <= rsp_count_r - RSP_CNT_ONE;
                default: rsp_count_r <= rsp_count_r;
            endcase
        end
    end

`ifdef DPRAM_REQ_STATS_EN
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    logic [15:0] stat_rd_cnt_r;
    logic [15:0] stat_wr_cnt_r;
    logic [15:0] stat_stall_cnt_r;

    // Saturating transfer and credit-stall counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_rd_cnt_r    <= 16'd0;
            stat_wr_cnt_r    <= 16'd0;
            stat_stall_cnt_r <= 16'd0;
        end else begin
            if (rd_acc_s && (stat_rd_cnt_r != STAT_MAX)) begin
                stat_rd_cnt_r <= stat_rd_cnt_r + 16'd1;
            end
            if (wr_acc_s && (stat_wr_cnt_r != STAT_MAX)) begin
                stat_wr_cnt_r <= stat_wr_cnt_r + 16'd1;
            end
            if (!cmd_empty_s && !ram_valid_s && (stat_stall_cnt_r != STAT_MAX)) begin
                stat_stall_cnt_r <= stat_stall_cnt_r + 16'd1;
            end
        end
    end

    assign stat_rd_cnt    = stat_rd_cnt_r;
    assign stat_wr_cnt    = stat_wr_cnt_r;
    assign stat_stall_cnt = stat_stall_cnt_r;
`endif

endmodule

// File: tb/tb_dpram_port_requester.sv
// -----------------------------------------------------------------------------
// Testbench for dpram_port_requester: a behavioural RAM (one-cycle read
// latency, unwritten locations read as addr ^ 8'h5A) sits on the RAM port,
// and a monitor logs RAM transfers and client response pops. Scenario tasks
// drive directed stimulus and compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dpram_port_requester;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       req_we;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       ram_valid;
    logic       ram_ready;
    logic [7:0] ram_q = 8'h00;
`ifdef DPRAM_REQ_STATS_EN
    logic [15:0] stat_rd_cnt;
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    dpram_port_requester dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_we    (req_we),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .ram_valid (ram_valid),
        .ram_ready (ram_ready),
        .ram_q     (ram_q)
`ifdef DPRAM_REQ_STATS_EN
        ,
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM
    logic [7:0]   mem [256];
    logic [255:0] wr_mask = '0;
    always @(posedge clk) begin
        if (ram_valid && ram_ready) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_data;
                wr_mask[ram_addr] <= 1'b1;
            end else begin
                ram_q <= wr_mask[ram_addr] ? mem[ram_addr] : (ram_addr ^ 8'h5A);
            end
        end
    end

    // Monitor: RAM transfers and response pops
    int         cyc = 0;
    logic [7:0] xa_q[$];
    logic       xw_q[$];
    int         xc_q[$];
    logic [7:0] rsp_q[$];
    always @(posedge clk) begin
        cyc++;
        if (ram_valid && ram_ready) begin
            xa_q.push_back(ram_addr);
            xw_q.push_back(ram_we);
            xc_q.push_back(cyc);
        end
        if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
    end

    task automatic clear_logs();
        xa_q.delete(); xw_q.delete(); xc_q.delete(); rsp_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Present one command starting at a negedge; returns at the negedge after acceptance
    task automatic push_cmd(input logic we, input logic [7:0] a, input logic [7:0] d);
        int budget;
        budget = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL push_timeout: req_ready stayed %0b, required 1 (addr %0h)", req_ready, a);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        n_cmp++; if (ram_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ram_valid: got %b required 0", ram_valid); end
        n_cmp++; if ({ram_addr, ram_data, ram_we} !== 17'h0) begin n_fail++; $display("FAIL rst_ram_bus: got %h/%h/%b required 0", ram_addr, ram_data, ram_we); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: got %h required 00", rsp_data); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        clear_logs();
        rsp_ready = 1'b1; ram_ready = 1'b1;
        push_cmd(1'b1, 8'h10, 8'hA5);
        n_cmp++; if (ram_valid !== 1'b1 || ram_addr !== 8'h10 || ram_we !== 1'b1 || ram_data !== 8'hA5) begin
            n_fail++; $display("FAIL wr_latency: got v=%b a=%h we=%b d=%h required 1/10/1/a5", ram_valid, ram_addr, ram_we, ram_data); end
        push_cmd(1'b0, 8'h10, 8'h00);
        idle(6);
        n_cmp++; if (xa_q.size() !== 2) begin n_fail++; $display("FAIL wr_rd_xfers: got %0d required 2", xa_q.size()); end
        else if (xa_q[0] !== 8'h10 || xw_q[0] !== 1'b1 || xa_q[1] !== 8'h10 || xw_q[1] !== 1'b0) begin
            n_fail++; $display("FAIL wr_rd_order: got %h/%b %h/%b required 10/1 10/0", xa_q[0], xw_q[0], xa_q[1], xw_q[1]); end
        n_cmp++; if (rsp_q.size() !== 1) begin n_fail++; $display("FAIL wr_rd_rsp_count: got %0d required 1", rsp_q.size()); end
        else if (rsp_q[0] !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_rsp_data: got %h required a5", rsp_q[0]); end
    endtask

    task automatic test_cmd_full();
        clear_logs();
        ram_ready = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 8'h20 + 8'(i), 8'h30 + 8'(i));
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b required 0", req_ready); end
        n_cmp++; if (ram_valid !== 1'b1 || ram_addr !== 8'h20 || ram_data !== 8'h30) begin
            n_fail++; $display("FAIL full_head: got v=%b a=%h d=%h required 1/20/30", ram_valid, ram_addr, ram_data); end
        @(negedge clk);
        n_cmp++; if (ram_addr !== 8'h20) begin n_fail++; $display("FAIL full_hold: got %h required 20", ram_addr); end
        ram_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || ram_addr !== 8'h21) begin
            n_fail++; $display("FAIL full_after_pop: got ready=%b a=%h required 1/21", req_ready, ram_addr); end
        idle(5);
        n_cmp++; if (xa_q.size() !== 4) begin n_fail++; $display("FAIL full_xfers: got %0d required 4", xa_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (xa_q[i] !== 8'h20 + 8'(i) || xc_q[i] !== xc_q[0] + i) begin
                    n_fail++; $display("FAIL full_order%0d: got a=%h cyc+%0d required %h cyc+%0d", i, xa_q[i], xc_q[i] - xc_q[0], 8'h20 + 8'(i), i); end
            end
        end
    endtask

    task automatic test_credit_stall();
        logic [7:0] exp_d [6];
        exp_d = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F};
        clear_logs();
        rsp_ready = 1'b0; ram_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_cmd(1'b0, 8'(i), 8'h00);
        idle(3);
        n_cmp++; if (xa_q.size() !== 4) begin n_fail++; $display("FAIL credit_reads: got %0d required 4", xa_q.size()); end
        n_cmp++; if (ram_valid !== 1'b0 || ram_addr !== 8'h00) begin
            n_fail++; $display("FAIL credit_stall: got v=%b a=%h required 0/00", ram_valid, ram_addr); end
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin
            n_fail++; $display("FAIL credit_rsp_head: got v=%b d=%h required 1/5a", rsp_valid, rsp_data); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (ram_valid !== 1'b1 || ram_addr !== 8'h04) begin
            n_fail++; $display("FAIL credit_resume: got v=%b a=%h required 1/04", ram_valid, ram_addr); end
        @(negedge clk);
        rsp_ready = 1'b1;
        idle(12);
        n_cmp++; if (rsp_q.size() !== 6) begin n_fail++; $display("FAIL credit_rsp_count: got %0d required 6", rsp_q.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++; if (rsp_q[i] !== exp_d[i]) begin n_fail++; $display("FAIL credit_rsp%0d: got %h required %h", i, rsp_q[i], exp_d[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [4];
        logic       prev_v, prev_rdy;
        logic [7:0] prev_a;
        exp_d = '{8'h5B, 8'h58, 8'h59, 8'h5E};
        clear_logs();
        rsp_ready = 1'b1; ram_ready = 1'b1;
        prev_v = 1'b0; prev_rdy = 1'b1; prev_a = 8'h00;
        fork
            begin
                for (int i = 1; i <= 4; i++) push_cmd(1'b0, 8'(i), 8'h00);
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    if (prev_v && !prev_rdy) begin
                        n_cmp++; if (ram_valid !== 1'b1 || ram_addr !== prev_a) begin
                            n_fail++; $display("FAIL bp_hold: got v=%b a=%h required 1/%h", ram_valid, ram_addr, prev_a); end
                    end
                    prev_v = ram_valid; prev_a = ram_addr;
                    ram_ready = (k % 2 == 0);
                    prev_rdy = ram_ready;
                    @(negedge clk);
                end
                ram_ready = 1'b1;
            end
        join
        idle(8);
        n_cmp++; if (xa_q.size() !== 4) begin n_fail++; $display("FAIL bp_xfers: got %0d required 4", xa_q.size()); end
        n_cmp++; if (rsp_q.size() !== 4) begin n_fail++; $display("FAIL bp_rsp_count: got %0d required 4", rsp_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (rsp_q[i] !== exp_d[i]) begin n_fail++; $display("FAIL bp_rsp%0d: got %h required %h", i, rsp_q[i], exp_d[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        rsp_ready = 1'b0; ram_ready = 1'b1;
        push_cmd(1'b0, 8'h00, 8'h00);
        push_cmd(1'b0, 8'h01, 8'h00);
        idle(4);
        ram_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(1'b1, 8'h40 + 8'(i), 8'hC0);
        n_cmp++; if (rsp_valid !== 1'b1 || ram_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got rsp_v=%b ram_v=%b required 1/1", rsp_valid, ram_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b required 0", req_ready); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || ram_valid !== 1'b0 || rsp_data !== 8'h00) begin
            n_fail++; $display("FAIL mid_rst_outputs: got rsp_v=%b ram_v=%b d=%h required 0/0/00", rsp_valid, ram_valid, rsp_data); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b required 1", req_ready); end
        clear_logs();
        ram_ready = 1'b1; rsp_ready = 1'b1;
        idle(6);
        n_cmp++; if (xa_q.size() !== 0 || rsp_q.size() !== 0) begin
            n_fail++; $display("FAIL mid_stale: got xfers=%0d rsps=%0d required 0/0", xa_q.size(), rsp_q.size()); end
    endtask

`ifdef DPRAM_REQ_STATS_EN
    task automatic test_stats();
        ram_ready = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_cmd(1'b1, 8'h60 + 8'(i), 8'h70 + 8'(i));
        for (int i = 0; i < 3; i++) push_cmd(1'b0, 8'h60 + 8'(i), 8'h00);
        idle(5);
        n_cmp++; if (stat_wr_cnt !== 16'd5) begin n_fail++; $display("FAIL stat_wr: got %0d required 5", stat_wr_cnt); end
        n_cmp++; if (stat_rd_cnt !== 16'd3) begin n_fail++; $display("FAIL stat_rd: got %0d required 3", stat_rd_cnt); end
        for (int i = 0; i < 65532; i++) push_cmd(1'b0, 8'h07, 8'h00);
        idle(5);
        n_cmp++; if (stat_rd_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stat_rd_max: got %h required ffff", stat_rd_cnt); end
        push_cmd(1'b0, 8'h07, 8'h00);
        idle(5);
        n_cmp++; if (stat_rd_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stat_rd_sat: got %h required ffff", stat_rd_cnt); end
        n_cmp++; if (stat_wr_cnt !== 16'd5) begin n_fail++; $display("FAIL stat_wr_hold: got %0d required 5", stat_wr_cnt); end
    endtask
`endif

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 8'h00; req_data = 8'h00; req_we = 1'b0;
        rsp_ready = 1'b1; ram_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_cmd_full();
        test_credit_stall();
        test_backpressure();
        test_reset_mid();
`ifdef DPRAM_REQ_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
